alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//  Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder.
//  ADD/SUB/AND/OR/XOR/SLT complete in one cycle. SLL/SRL/SRA are done iteratively, one bit per cycle.
//  A valid/ready handshake sits on both the input and the result.
//  Sits between ID/EX operand latch and EX/MEM register; stalls pipeline via in_ready/out_valid.
// PARAMETERS
//  WIDTH    32              operand/result width in bits
//  SHAMT_W  $clog2(WIDTH)   shift-amount width (5 for WIDTH=32); only operand_b[SHAMT_W-1:0] used
// PORTS
//  clk             in   1        single clock, rising edge
//  reset           in   1        synchronous, active-high
//  in_valid        in   1        ALUcontrol_In/operand_a/operand_b valid this cycle
//  in_ready        out  1        block can accept an operation
//  ALUcontrol_In   in   4        0000 ADD,0001 SUB,0010 AND,0011 OR,0100 XOR,0101 SLL,0110 SRL,0111 SRA,1000 SLT
//  operand_a       in   WIDTH    rs1 value
//  operand_b       in   WIDTH    rs2 / immediate value; shift amount in low SHAMT_W bits
//  out_valid       out  1        result/zero valid
//  out_ready       in   1        consumer accepts result
//  result          out  WIDTH    registered result
//  zero            out  1        registered (result == 0)
//  busy            out  1        high in SHIFT or DONE state
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset is synchronous and active-high.
//  Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, busy=0, shift counter=0.
//  FSM states:
//   IDLE: in_ready=1. On in_valid&&in_ready, latch op and operands.
//    - Non-shift op, or shift with shamt==0: result computed, registered; go DONE.
//    - Shift with shamt!=0: load working reg=operand_a, cnt=shamt; go SHIFT.
//   SHIFT: each cycle shift working reg 1 bit (SLL: <<1 zero-fill; SRL: >>1 zero-fill; SRA: >>1 sign-fill).
//    - Decrement cnt; when cnt reaches 0, write result; go DONE.
//   DONE: out_valid=1; result/zero held stable while out_ready=0. On out_ready, go IDLE.
//  in_ready is 0 in SHIFT and DONE; operations are never overlapped; inputs are ignored when in_ready=0.
//  Latency (accept edge -> out_valid high): 1 cycle for non-shift ops and shamt=0; shamt+1 cycles for shifts.
//  Throughput: the next accept occurs no earlier than the cycle after the out_valid&&out_ready handshake.
//  Arithmetic:
//   - ADD/SUB: modulo 2^WIDTH, no overflow flag.
//   - SLT: signed compare, result = {WIDTH-1 zeros, (a<b)}.
//   - Logic ops are bitwise.
//  Codes 1001-1111: executed as ADD, matching the decoder default.
//  zero is updated with result in the same cycle and is meaningful only while out_valid=1.
//  Reset asserted in any state (including mid-SHIFT or DONE with out_ready=0):
//   - Abort the operation; return to reset values next edge.
//   - No out_valid is produced for the aborted operation.
//  in_valid and out_ready high in the same cycle while in DONE: only the output handshake completes;
//  the input is accepted in the following IDLE cycle if in_valid is still high.
// TESTING
//  1 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, zero=0, out_valid exactly 1 cycle after accept.
//  2 SUB a=b=0x1234 -> result 0, zero=1. SLT a=0xFFFFFFFF b=1 -> result 1; SLT a=1 b=0xFFFFFFFF -> result 0.
//  3 SRA a=0x80000000 b=31 -> result 0xFFFFFFFF after 32 cycles, in_ready low throughout.
//    SRL same operands -> result 0x00000001.
//  4 SLL a=1 b=0x25 -> shamt 5, result 0x20, 6-cycle latency. SLL b=0x20 -> shamt 0, result=a, 1-cycle latency.
//  5 out_ready held 0 for 5 cycles in DONE -> result/zero/out_valid stable; in_valid pulses ignored.
//    Release -> IDLE, in_ready=1.
//  6 Reset pulsed during SHIFT of a 20-bit SLL -> next cycle IDLE, out_valid=0, result=0.
//    A following ADD 2+3 -> result 5.

Source files
------------

// File: rtl/alu_seq_exec.sv
// Execution-stage ALU. Single-cycle ADD/SUB/AND/OR/XOR/SLT; SLL/SRL/SRA are
// iterated one bit position per cycle. Valid/ready handshake on both sides.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (ALUcontrol_In, operand_a, operand_b)
//   ALUcontrol_In       4-bit op code from the ALU control decoder
//   operand_a/operand_b rs1 and rs2/immediate; shift amount in operand_b[SHAMT_W-1:0]
//   out_valid/out_ready result handshake
//   result, zero        registered result and (result == 0)
//   busy                high while an operation is in flight (SHIFT or DONE)
module alu_seq_exec #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         ALUcontrol_In,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               busy
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_n;
  logic [SHAMT_W-1:0]   cnt_q, cnt_n;
  logic [WIDTH-1:0]     work_q, work_n;
  logic [3:0]           op_q, op_n;
  logic [WIDTH-1:0]     result_n;
  logic                 zero_n;
  logic [WIDTH-1:0]     shifted_c;
  logic                 in_is_shift_c;
  logic [SHAMT_W-1:0]   in_shamt_c;

  // Single-cycle datapath; unassigned codes fall back to ADD like the decoder.
  function automatic logic [WIDTH-1:0] alu_f(input logic [3:0]       op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = WIDTH'($signed(a) < $signed(b));
      default: r = a + b;
    endcase
    return r;
  endfunction

  assign in_is_shift_c = (ALUcontrol_In == OP_SLL) || (ALUcontrol_In == OP_SRL) ||
                         (ALUcontrol_In == OP_SRA);
  assign in_shamt_c    = operand_b[SHAMT_W-1:0];

  // One-bit step of the latched shift op.
  always_comb begin
    case (op_q)
      OP_SLL:  shifted_c = {work_q[WIDTH-2:0], 1'b0};
      OP_SRA:  shifted_c = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shifted_c = {1'b0, work_q[WIDTH-1:1]};
    endcase
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    work_n   = work_q;
    op_n     = op_q;
    result_n = result;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_n = ALUcontrol_In;
          if (in_is_shift_c && (in_shamt_c != '0)) begin
            work_n  = operand_a;
            cnt_n   = in_shamt_c;
            state_n = S_SHIFT;
          end else begin
            result_n = in_is_shift_c ? operand_a : alu_f(ALUcontrol_In, operand_a, operand_b);
            state_n  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        work_n = shifted_c;
        cnt_n  = cnt_q - SHAMT_W'(1);
        // Last step: the counter is about to reach zero.
        if (cnt_q == SHAMT_W'(1)) begin
          result_n = shifted_c;
          state_n  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    zero_n = (result_n == '0);
  end

  // State and registered outputs; handshake flags follow the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      op_q      <= OP_ADD;
      result    <= '0;
      zero      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      work_q    <= work_n;
      op_q      <= op_n;
      result    <= result_n;
      zero      <= zero_n;
      in_ready  <= (state_n == S_IDLE);
      out_valid <= (state_n == S_DONE);
      busy      <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed vector table, randomized
// operations against a behavioural model, and handshake/reset corner sequences.
module tb_alu_seq_exec;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUcontrol_In;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUcontrol_In(ALUcontrol_In), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: result and latency straight from the operation definitions.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    lat = 1;
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = a << sh;
      4'd6: res = a >> sh;
      4'd7: res = $signed(a) >>> sh;
      4'd8: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = a + b;
    endcase
    if (op >= 4'd5 && op <= 4'd7 && sh != 0) lat = sh + 1;
  endtask

  // Issue one op, measure latency, optionally stall the output for 'hold' cycles.
  // Entered and left just after a rising edge.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int hold);
    int cyc;
    bit ready_low;
    bit stable;
    logic [31:0] res_hold;
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk({name, " in_ready before issue"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; ALUcontrol_In = op; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; operand_a = $urandom; operand_b = $urandom;
    ALUcontrol_In = 4'($urandom);
    cyc = 1;
    ready_low = 1'b1;
    while (!out_valid && cyc < 200) begin
      if (in_ready || !busy) ready_low = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    chk({name, " out_valid seen"}, 32'(out_valid), 32'd1);
    chk({name, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({name, " result"}, result, exp_res);
    chk({name, " zero"}, 32'(zero), 32'(exp_res == 32'd0));
    chk({name, " in_ready low while busy"}, 32'({ready_low, in_ready, busy}), 32'b101);
    if (hold > 0) begin
      stable   = 1'b1;
      res_hold = result;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; ALUcontrol_In = 4'd1; operand_a = $urandom; operand_b = $urandom;
        @(posedge clk); #1;
        if (!out_valid || result !== res_hold || zero !== (res_hold == 32'd0) || in_ready)
          stable = 1'b0;
      end
      in_valid = 1'b0;
      chk({name, " stable under stall"}, 32'(stable), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " back to idle"}, 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  initial begin
    logic [31:0] eres;
    int          elat;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    bit          no_valid;

    vecs[0]  = '{"ADD ovf",   4'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1};
    vecs[1]  = '{"SUB eq",    4'd1, 32'h1234,     32'h1234,     32'h0,        1};
    vecs[2]  = '{"SLT neg",   4'd8, 32'hFFFFFFFF, 32'h1,        32'h1,        1};
    vecs[3]  = '{"SLT pos",   4'd8, 32'h1,        32'hFFFFFFFF, 32'h0,        1};
    vecs[4]  = '{"SRA 31",    4'd7, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32};
    vecs[5]  = '{"SRL 31",    4'd6, 32'h80000000, 32'd31,       32'h00000001, 32};
    vecs[6]  = '{"SLL 5",     4'd5, 32'h1,        32'h25,       32'h20,       6};
    vecs[7]  = '{"SLL 0",     4'd5, 32'h1,        32'h20,       32'h1,        1};
    vecs[8]  = '{"AND",       4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
    vecs[9]  = '{"OR",        4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1};
    vecs[10] = '{"XOR",       4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1};
    vecs[11] = '{"code 1111", 4'd15, 32'd5,       32'd6,        32'd11,       1};
    vecs[12] = '{"SRA pos",   4'd7, 32'h40000000, 32'd4,        32'h04000000, 5};
    vecs[13] = '{"SUB wrap",  4'd1, 32'd0,        32'd1,        32'hFFFFFFFF, 1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUcontrol_In = 4'd0; operand_a = 32'd0; operand_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 32'({in_ready, out_valid, zero, busy}), 32'b1000);
    chk("reset result", result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat,
             (i == 1) ? 5 : 0);

    // Output and input handshakes in the same DONE cycle: input waits one IDLE cycle.
    in_valid = 1'b1; ALUcontrol_In = 4'd0; operand_a = 32'd4; operand_b = 32'd4;
    @(posedge clk); #1;
    chk("overlap first valid", 32'({out_valid, in_ready}), 32'b10);
    ALUcontrol_In = 4'd0; operand_a = 32'd10; operand_b = 32'd20;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("overlap idle gap", 32'({out_valid, in_ready}), 32'b01);
    chk("overlap old result", result, 32'd8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("overlap second valid", 32'({out_valid, in_ready}), 32'b10);
    chk("overlap second result", result, 32'd30);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a 20-bit SLL aborts it without a result.
    in_valid = 1'b1; ALUcontrol_In = 4'd5; operand_a = 32'h3; operand_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid-shift busy", 32'({busy, in_ready, out_valid}), 32'b100);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort state", 32'({in_ready, out_valid, busy, zero}), 32'b1000);
    chk("abort result", result, 32'd0);
    no_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) no_valid = 1'b0;
    end
    chk("no valid after abort", 32'(no_valid), 32'd1);
    run_op("ADD after abort", 4'd0, 32'd2, 32'd3, 32'd5, 1, 0);

    // Randomized operations checked against the behavioural model.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 5 == 0) rb = ra;
      model(rop, ra, rb, eres, elat);
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, eres, elat,
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
